// File: rtl/hamming_uart_pkg.sv
// Shared encoder helpers, FSM state codes and UART framing constants.
package hamming_uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    // Hamming(7,4) codeword, bit0..bit6 = p1 p2 d0 p3 d1 d2 d3
    function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // Overall parity over the 7-bit codeword (SECDED extension bit)
    function automatic logic ext_parity(input logic [6:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hamming_uart_tx_fifo.sv
// Hamming(7,4)/SECDED nibble encoder feeding a FIFO-buffered back-to-back UART transmitter.
module hamming_uart_tx_fifo
    import hamming_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned EXT_PARITY   = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [3:0]                    in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W     = $clog2(STOP_CLKS);
    localparam int unsigned BIT_W     = $clog2(UART_DATA_BITS);

    uart_state_t      state;
    uart_state_t      state_n;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_n;
    logic [BIT_W-1:0] bit_idx;
    logic [BIT_W-1:0] bit_n;
    logic [7:0]       shreg;
    logic [7:0]       sh_n;
    logic             tx_n;
    logic             busy_n;
    logic             fd_n;

    logic [6:0]       code_c;
    logic [7:0]       enc_byte_c;
    logic             push_c;
    logic             pop_c;
    logic             load_c;
    logic [7:0]       fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;

    // Combinational encode of the offered nibble
    assign code_c     = hamming74_encode(in_data);
    assign enc_byte_c = {(EXT_PARITY != 0) ? ext_parity(code_c) : 1'b0, code_c};

    // Ready follows occupancy only; a pop in the same cycle does not open a slot early
    assign in_ready = ~rst & ~fifo_full;
    assign push_c   = in_valid & in_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .wr_data (enc_byte_c),
        .pop     (pop_c),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and registered-output logic for the framing FSM
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + CNT_W'(1);
        bit_n   = bit_idx;
        sh_n    = shreg;
        tx_n    = tx;
        busy_n  = tx_busy;
        fd_n    = 1'b0;
        pop_c   = 1'b0;
        load_c  = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_n   = UART_IDLE_LEVEL;
                baud_n = '0;
                if (!fifo_empty) begin
                    load_c = 1'b1;
                end
            end
            ST_START: begin
                if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    state_n = ST_DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            ST_DATA: begin
                if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    baud_n = '0;
                    if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_n = ST_STOP;
                        tx_n    = UART_IDLE_LEVEL;
                    end else begin
                        bit_n = bit_idx + BIT_W'(1);
                        sh_n  = shreg >> 1;
                        tx_n  = shreg[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_cnt == CNT_W'(STOP_CLKS - 1)) begin
                    fd_n   = 1'b1;
                    baud_n = '0;
                    if (!fifo_empty) begin
                        load_c = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = UART_IDLE_LEVEL;
                busy_n  = 1'b0;
            end
        endcase

        // Pop the FIFO head straight into the start bit, from IDLE or end of STOP
        if (load_c) begin
            pop_c   = 1'b1;
            sh_n    = fifo_rd;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
            baud_n  = '0;
            state_n = ST_START;
        end
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= UART_IDLE_LEVEL;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            tx         <= tx_n;
            tx_busy    <= busy_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_hamming_uart_tx_fifo.sv
// Scoreboard bench: instance A (CPB=4, SECDED, 1 stop) with timing model and UART receiver,
// instance B (CPB=16, no ext parity, 2 stop bits) swept over all 16 nibbles.
module tb_hamming_uart_tx_fifo;

    localparam int CPB_A   = 4;
    localparam int DEPTH_A = 4;
    localparam int L_A     = 10 * CPB_A;
    localparam int CPB_B   = 16;
    localparam int L_B     = 11 * CPB_B;
    localparam int GUARD   = 3000;

    logic       clk;
    logic       rst_a, in_valid_a, in_ready_a, tx_a, busy_a, fd_a;
    logic [3:0] in_data_a;
    logic [2:0] cnt_a;
    logic       rst_b, in_valid_b, in_ready_b, tx_b, busy_b, fd_b;
    logic [3:0] in_data_b;
    logic [2:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];
    int n_exp_frames = 0;
    int n_frames = 0;
    bit done_b = 0;

    hamming_uart_tx_fifo #(
        .CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH_A), .EXT_PARITY(1), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .tx(tx_a), .tx_busy(busy_a),
        .frame_done(fd_a), .fifo_count(cnt_a)
    );

    hamming_uart_tx_fifo #(
        .CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4), .EXT_PARITY(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .tx(tx_b), .tx_busy(busy_b),
        .frame_done(fd_b), .fifo_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound of %0d cycles expired at t=%0t", name, GUARD, $time);
    endtask

    // Reference encoder: generic Hamming layout, parity bits at positions 1,2,4 (1-based)
    function automatic logic [7:0] ref_encode(input logic [3:0] d, input bit ext);
        logic [7:0] cw;
        logic       par;
        int         k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 7; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int q = 1; q <= 7; q++) begin
                if (q != p && (q & p) != 0) par = par ^ cw[q];
            end
            cw[p] = par;
        end
        return {ext ? ^cw[7:1] : 1'b0, cw[7:1]};
    endfunction

    // Cycle-level timing model of instance A: frame timeline, FIFO occupancy, handshake
    bit m_rst_prev = 1'b1;
    bit m_pend     = 1'b0;
    bit m_busy     = 1'b0;
    bit m_fd       = 1'b0;
    int m_cnt      = 0;
    int m_fcyc     = 0;
    int m_slot;

    always @(negedge clk) begin
        m_fd = 1'b0;
        if (m_rst_prev) begin
            m_cnt  = 0;
            m_busy = 1'b0;
            m_fcyc = 0;
        end else begin
            if (m_busy) begin
                m_fcyc++;
                if (m_fcyc == L_A) begin
                    m_fd   = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (!m_busy && m_cnt > 0) begin
                m_cnt--;
                m_busy = 1'b1;
                m_fcyc = 0;
            end
            if (m_pend) m_cnt++;
        end
        chk("tx_busy", busy_a, m_busy);
        chk("fifo_count", cnt_a, m_cnt);
        chk("frame_done", fd_a, m_fd);
        chk("in_ready", in_ready_a, (!rst_a && m_cnt < DEPTH_A));
        if (!m_busy) begin
            chk("tx_idle_level", tx_a, 1);
        end else begin
            m_slot = m_fcyc / CPB_A;
            if (m_slot == 0) chk("tx_start_bit", tx_a, 0);
            else if (m_slot >= 9) chk("tx_stop_bit", tx_a, 1);
        end
        m_pend     = in_valid_a && in_ready_a;
        m_rst_prev = rst_a;
    end

    // UART receiver for instance A: decodes each frame and pops the scoreboard at frame_done
    bit         r_rst_prev = 1'b1;
    bit         r_act      = 1'b0;
    int         r_k        = 0;
    logic [7:0] r_byte     = '0;

    always @(negedge clk) begin
        if (r_rst_prev) begin
            r_act = 1'b0;
        end else begin
            if (r_act) begin
                r_k++;
                if (r_k >= CPB_A && r_k < 9 * CPB_A && (r_k % CPB_A) == CPB_A / 2)
                    r_byte[r_k / CPB_A - 1] = tx_a;
            end
            if (fd_a) begin
                chk("scoreboard_has_entry", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) chk("rx_byte", r_byte, sb_q.pop_front());
                n_frames++;
                r_act = 1'b0;
            end
            if (!r_act && tx_a == 1'b0) begin
                r_act  = 1'b1;
                r_k    = 0;
                r_byte = '0;
            end
        end
        r_rst_prev = rst_a;
    end

    // Offer one nibble on A (called just after a rising edge); expected byte enters the scoreboard
    task automatic push_a(input logic [3:0] n, input logic [7:0] exp);
        int guard;
        guard      = 0;
        in_valid_a = 1'b1;
        in_data_a  = n;
        forever begin
            @(negedge clk);
            if (in_ready_a) begin
                sb_q.push_back(exp);
                n_exp_frames++;
                break;
            end
            guard++;
            if (guard > GUARD) begin
                timeout("push_a");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (!busy_a && cnt_a == 0) break;
            guard++;
            if (guard > GUARD) begin
                timeout("wait_idle_a");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd_a();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (fd_a) break;
            guard++;
            if (guard > GUARD) begin
                timeout("wait_fd_a");
                break;
            end
        end
    endtask

    // Instance A stimulus
    initial begin : bench_a
        logic [3:0] n;
        int guard;
        rst_a      = 1'b1;
        in_valid_a = 1'b0;
        in_data_a  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(posedge clk);
        #1;

        // Directed encodings with hard expected bytes
        push_a(4'h1, 8'h87);
        wait_idle_a();
        push_a(4'hB, 8'h55);
        wait_idle_a();

        // Back-to-back: hold valid across nibbles 0..5
        in_valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data_a = 4'(i);
            guard = 0;
            forever begin
                @(negedge clk);
                if (in_ready_a) break;
                guard++;
                if (guard > GUARD) begin
                    timeout("b2b_push");
                    break;
                end
            end
            sb_q.push_back(ref_encode(4'(i), 1'b1));
            n_exp_frames++;
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
        wait_idle_a();

        // Simultaneous push and pop with three bytes queued
        for (int i = 0; i < 4; i++) begin
            n = 4'($urandom);
            push_a(n, ref_encode(n, 1'b1));
        end
        wait_fd_a();
        @(posedge clk);
        #1;
        n = 4'($urandom);
        push_a(n, ref_encode(n, 1'b1));
        repeat (L_A - 3) @(posedge clk);
        #1;
        n          = 4'($urandom);
        in_valid_a = 1'b1;
        in_data_a  = n;
        @(negedge clk);
        chk("simul_in_ready_at_3", in_ready_a, 1);
        sb_q.push_back(ref_encode(n, 1'b1));
        n_exp_frames++;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("simul_count_held_3", cnt_a, 3);
        chk("simul_pop_same_edge", fd_a, 1);
        @(posedge clk);
        #1;
        wait_idle_a();

        // Reset during data bit 3
        n = 4'($urandom);
        push_a(n, ref_encode(n, 1'b1));
        guard = 0;
        forever begin
            @(negedge clk);
            if (tx_a == 1'b0) break;
            guard++;
            if (guard > GUARD) begin
                timeout("wait_start_bit");
                break;
            end
        end
        repeat (4 * CPB_A + 1) @(posedge clk);
        #1;
        rst_a = 1'b1;
        n_exp_frames -= sb_q.size();
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tx", tx_a, 1);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_count", cnt_a, 0);
        chk("rst_mid_frame_done", fd_a, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;
        n = 4'($urandom);
        push_a(n, ref_encode(n, 1'b1));
        wait_idle_a();

        // Random traffic with random gaps
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            n = 4'($urandom);
            push_a(n, ref_encode(n, 1'b1));
        end
        wait_idle_a();
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("frames_received", n_frames, n_exp_frames);

        guard = 0;
        while (!done_b) begin
            @(posedge clk);
            guard++;
            if (guard > 10 * GUARD) begin
                timeout("wait_bench_b");
                break;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Instance B: every nibble, one frame at a time, with 2 stop bits at 16 clocks/bit
    initial begin : bench_b
        logic [7:0] rx_arr [16];
        logic [7:0] rxb;
        bit         stop_ok;
        bit         fd_early;
        int         guard;
        int         min_d;
        int         d;
        rst_b      = 1'b1;
        in_valid_b = 1'b0;
        in_data_b  = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b_rst_tx", tx_b, 1);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_count", cnt_b, 0);
        chk("b_rst_in_ready", in_ready_b, 0);
        chk("b_rst_frame_done", fd_b, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;

        for (int n = 0; n < 16; n++) begin
            in_valid_b = 1'b1;
            in_data_b  = 4'(n);
            guard = 0;
            forever begin
                @(negedge clk);
                if (in_ready_b) break;
                guard++;
                if (guard > GUARD) begin
                    timeout("b_push");
                    break;
                end
            end
            @(posedge clk);
            #1;
            in_valid_b = 1'b0;
            guard = 0;
            forever begin
                @(negedge clk);
                if (tx_b == 1'b0) break;
                guard++;
                if (guard > GUARD) begin
                    timeout("b_start_bit");
                    break;
                end
            end
            rxb      = '0;
            stop_ok  = 1'b1;
            fd_early = 1'b0;
            for (int k = 1; k <= L_B; k++) begin
                @(negedge clk);
                if (k >= CPB_B && k < 9 * CPB_B && (k % CPB_B) == CPB_B / 2)
                    rxb[k / CPB_B - 1] = tx_b;
                if (k >= 9 * CPB_B && k < L_B && tx_b != 1'b1) stop_ok = 1'b0;
                if (k < L_B && fd_b) fd_early = 1'b1;
                if (k == L_B) begin
                    chk("b_frame_done_at_176", fd_b, 1);
                    chk("b_busy_low_at_end", busy_b, 0);
                end
            end
            chk("b_stop_32_cycles_high", stop_ok, 1);
            chk("b_no_early_frame_done", fd_early, 0);
            chk("b_byte", rxb, ref_encode(4'(n), 1'b0));
            if (n == 1) chk("b_byte_nibble1", rxb, 8'h07);
            rx_arr[n] = rxb;
            @(posedge clk);
            #1;
        end

        min_d = 8;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j < 16; j++) begin
                d = $countones(rx_arr[i] ^ rx_arr[j]);
                if (d < min_d) min_d = d;
            end
        end
        chk("b_min_hamming_distance_ge3", (min_d >= 3), 1);
        done_b = 1'b1;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
